// File: rtl/vend.sv
// Newspaper vending controller: Moore FSM crediting nickels and dimes
// toward a 15c price, pulsing newspaper for one cycle per sale.
module vend (
  input  logic [1:0] coin,
  input  logic       clock,
  input  logic       reset,
  output logic       newspaper
);

  localparam logic [1:0] S0  = 2'b00;
  localparam logic [1:0] S5  = 2'b01;
  localparam logic [1:0] S10 = 2'b10;
  localparam logic [1:0] S15 = 2'b11;

  localparam logic [1:0] NONE   = 2'b00;
  localparam logic [1:0] NICKEL = 2'b01;
  localparam logic [1:0] DIME   = 2'b10;

  logic [1:0] state;
  logic [1:0] nxt;
  logic       nxt_paper;
  logic       paper_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= S0;
      paper_q <= 1'b0;
    end else begin
      state   <= nxt;
      paper_q <= nxt_paper;
    end
  end

  // Code 2'b11 falls into the default arms and acts as no coin.
  always_comb begin
    nxt = state;
    unique case (state)
      S0: begin
        if (coin == NICKEL)
          nxt = S5;
        else if (coin == DIME)
          nxt = S10;
      end
      S5: begin
        if (coin == NICKEL)
          nxt = S10;
        else if (coin == DIME)
          nxt = S15;
      end
      S10: begin
        if (coin == NICKEL || coin == DIME)
          nxt = S15;
      end
      S15: nxt = S0;
      default: nxt = S0;
    endcase
  end

  // Flop the decode so the actuator never sees state-bit glitches.
  always_comb begin
    nxt_paper = (nxt == S15);
    newspaper = paper_q;
  end

  logic unused_none;
  assign unused_none = (NONE == coin);

endmodule

// File: tb/tb_vend.sv
// Directed bench for vend: checks credit state and newspaper
// pulse after each coin, plus reset and edge cases.
module tb_vend;

  logic [1:0] coin;
  logic       clock;
  logic       reset;
  logic       newspaper;

  int checks = 0;
  int fails  = 0;

  vend dut (
    .coin      (coin),
    .clock     (clock),
    .reset     (reset),
    .newspaper (newspaper)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [2:0] obs,
                     input logic [2:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: got state/paper %b, want %b", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [1:0] c, input logic [1:0] s,
                      input logic p, input string tag);
    @(negedge clock);
    coin = c;
    @(posedge clock);
    #1;
    chk(tag, {dut.state, newspaper}, {s, p});
  endtask

  initial begin
    coin  = 2'b00;
    reset = 1'b1;
    #3;
    chk("reset_async", {dut.state, newspaper}, 3'b000);
    repeat (3) @(posedge clock);
    #1;
    chk("reset_held", {dut.state, newspaper}, 3'b000);
    @(negedge clock);
    reset = 1'b0;

    // three nickels
    step(2'b01, 2'b01, 1'b0, "n1");
    step(2'b00, 2'b01, 1'b0, "n1_idle");
    step(2'b01, 2'b10, 1'b0, "n2");
    step(2'b00, 2'b10, 1'b0, "n2_idle");
    step(2'b01, 2'b11, 1'b1, "n3_pulse");
    step(2'b00, 2'b00, 1'b0, "n3_after");

    // nickel then dime
    step(2'b01, 2'b01, 1'b0, "nd_n");
    step(2'b00, 2'b01, 1'b0, "nd_idle");
    step(2'b10, 2'b11, 1'b1, "nd_pulse");
    step(2'b00, 2'b00, 1'b0, "nd_after");

    // two dimes, excess forfeited
    step(2'b10, 2'b10, 1'b0, "dd_d1");
    step(2'b00, 2'b10, 1'b0, "dd_idle");
    step(2'b10, 2'b11, 1'b1, "dd_pulse");
    step(2'b00, 2'b00, 1'b0, "dd_after");
    step(2'b01, 2'b01, 1'b0, "dd_no_residual");
    step(2'b01, 2'b10, 1'b0, "dd_n2");
    step(2'b01, 2'b11, 1'b1, "dd_n3");
    step(2'b00, 2'b00, 1'b0, "dd_clear");

    // dime then nickel
    step(2'b10, 2'b10, 1'b0, "dn_d");
    step(2'b00, 2'b10, 1'b0, "dn_idle");
    step(2'b01, 2'b11, 1'b1, "dn_pulse");
    step(2'b00, 2'b00, 1'b0, "dn_after");

    // invalid code holds S5; coin during S15 not credited
    step(2'b01, 2'b01, 1'b0, "inv_n");
    step(2'b11, 2'b01, 1'b0, "inv_hold1");
    step(2'b11, 2'b01, 1'b0, "inv_hold2");
    step(2'b10, 2'b11, 1'b1, "inv_then_dime");
    step(2'b01, 2'b00, 1'b0, "s15_coin_ignored");
    step(2'b00, 2'b00, 1'b0, "s15_no_credit");

    // long idle in S10
    step(2'b10, 2'b10, 1'b0, "idle_d");
    for (int i = 0; i < 100; i++)
      step(2'b00, 2'b10, 1'b0, "idle_hold");

    // async reset mid-cycle from S10
    reset = 1'b1;
    #1;
    chk("reset_mid_s10", {dut.state, newspaper}, 3'b000);
    @(negedge clock);
    reset = 1'b0;

    // reset during the S15 cycle kills the pulse
    step(2'b10, 2'b10, 1'b0, "rs_d");
    step(2'b01, 2'b11, 1'b1, "rs_pulse");
    reset = 1'b1;
    #1;
    chk("reset_in_s15", {dut.state, newspaper}, 3'b000);
    @(negedge clock);
    coin  = 2'b00;
    reset = 1'b0;
    step(2'b01, 2'b01, 1'b0, "post_reset_n");
    step(2'b00, 2'b01, 1'b0, "post_reset_idle");

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
